// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus byte-write bus towards instruction memory.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  // Environment side: drives the byte stream, observes the memory writes.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-serial loader for the instruction memory. Accepts
// length / payload / checksum frames, writes payload bytes in order and
// releases the processor (cpu_run) once the checksum verifies.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic [ADDR_W-1:0] words_loaded,
  output logic              busy,
  output logic              cpu_run,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  // Counter is two bits wider than the byte address so it can be compared
  // directly against 4*N.
  localparam int unsigned CW        = ADDR_W + 2;
  localparam logic [7:0]  MAX_WORDS = 8'(MEM_BYTES / 4);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              run_q, run_d;
  logic              err_q, err_d;

  logic in_ready_w;
  logic xfer;
  logic start_ok;
  logic len_bad;
  logic last_byte;
  logic chk_ok;

  assign in_ready_w = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign xfer       = bus.in_valid && in_ready_w;
  assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign len_bad    = (bus.in_data == 8'd0) || (bus.in_data > MAX_WORDS);
  assign last_byte  = ((cnt_q + CW'(1)) == {len_q, 2'b00});
  assign chk_ok     = (bus.in_data == xor_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_LEN;
      S_LEN:  if (xfer) state_d = len_bad ? S_ERR : S_DATA;
      S_DATA: if (xfer && last_byte) state_d = S_CHK;
      S_CHK:  if (xfer) state_d = chk_ok ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and the load datapath.
  always_comb begin
    busy_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
    run_d   = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    len_d   = len_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start_ok) begin
      cnt_d = '0;
      xor_d = '0;
    end
    if (xfer) begin
      case (state_q)
        S_LEN:  len_d = bus.in_data[ADDR_W-1:0];
        S_DATA: begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = bus.in_data;
          cnt_d   = cnt_q + CW'(1);
          xor_d   = xor_q ^ bus.in_data;
        end
        S_CHK:  if (chk_ok) words_d = len_q;
        default: ;
      endcase
    end
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      xor_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      len_q   <= len_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign words_loaded  = words_q;
  assign busy          = busy_q;
  assign cpu_run       = run_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, bad checksum, length bounds,
// full memory, stalls with stray start, async reset mid-load, reload.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [4:0] words_loaded;
  logic busy, cpu_run, err;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(5)) bus ();

  imem_loader #(.MEM_BYTES(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .words_loaded (words_loaded),
    .busy         (busy),
    .cpu_run      (cpu_run),
    .err          (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled mid-cycle.
  logic [4:0] wr_addr [0:63];
  logic [7:0] wr_data [0:63];
  int         wr_cyc  [0:63];
  int         wr_n = 0;

  always @(negedge clk) begin
    if (bus.mem_we && wr_n < 64) begin
      wr_addr[wr_n] = bus.mem_addr;
      wr_data[wr_n] = bus.mem_wdata;
      wr_cyc[wr_n]  = cyc;
      wr_n = wr_n + 1;
    end
  end

  logic [7:0] frame [0:40];
  int  flen = 0;
  int  start_at = -1;
  bit  gaps = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".in_ready"},     32'(bus.in_ready),  32'd0);
    check({tag, ".mem_we"},       32'(bus.mem_we),    32'd0);
    check({tag, ".mem_addr"},     32'(bus.mem_addr),  32'd0);
    check({tag, ".mem_wdata"},    32'(bus.mem_wdata), 32'd0);
    check({tag, ".words_loaded"}, 32'(words_loaded),  32'd0);
    check({tag, ".busy"},         32'(busy),          32'd0);
    check({tag, ".cpu_run"},      32'(cpu_run),       32'd0);
    check({tag, ".err"},          32'(err),           32'd0);
  endtask

  // Present one byte and hold it until it transfers; returns on a negedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0 && n < 4) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
        n++;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hA5;
  endtask

  task automatic send_frame();
    for (int i = 0; i < flen; i++) begin
      if (i == start_at) start = 1'b1;
      send_byte(frame[i]);
      start = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_nominal(input logic [7:0] chk);
    frame[0] = 8'h02;
    frame[1] = 8'h8C; frame[2] = 8'h01; frame[3] = 8'h00; frame[4] = 8'h04;
    frame[5] = 8'hAC; frame[6] = 8'h02; frame[7] = 8'h00; frame[8] = 8'h08;
    frame[9] = chk;
    flen = 10;
  endtask

  task automatic check_writes(input int n, input bit consecutive);
    check("wr_count", 32'(wr_n), 32'(n));
    for (int i = 0; i < n && i < wr_n; i++) begin
      check($sformatf("wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("wr_data[%0d]", i), 32'(wr_data[i]), 32'(frame[i+1]));
      if (consecutive && i > 0)
        check($sformatf("wr_cycle[%0d]", i), 32'(wr_cyc[i]), 32'(wr_cyc[0] + i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE refuses bytes
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("idle.in_ready", 32'(bus.in_ready), 32'd0);
    check("idle.busy", 32'(busy), 32'd0);
    bus.in_valid = 1'b0;

    // Nominal 2-word load; checksum is the XOR of the eight payload bytes
    wr_n = 0;
    pulse_start();
    check("nom.busy_after_start", 32'(busy), 32'd1);
    check("nom.ready_after_start", 32'(bus.in_ready), 32'd1);
    set_nominal(8'h2F);
    send_frame();
    check("nom.cpu_run", 32'(cpu_run), 32'd1);
    check("nom.err", 32'(err), 32'd0);
    check("nom.busy", 32'(busy), 32'd0);
    check("nom.in_ready", 32'(bus.in_ready), 32'd0);
    check("nom.words_loaded", 32'(words_loaded), 32'd2);
    check_writes(8, 1'b1);

    // Checksum mismatch
    wr_n = 0;
    pulse_start();
    check("bad.cpu_run_dropped", 32'(cpu_run), 32'd0);
    set_nominal(8'hFF);
    send_frame();
    check("bad.err", 32'(err), 32'd1);
    check("bad.cpu_run", 32'(cpu_run), 32'd0);
    check("bad.words_loaded", 32'(words_loaded), 32'd2);
    check_writes(8, 1'b1);

    // N = 0
    wr_n = 0;
    pulse_start();
    check("len0.err_dropped", 32'(err), 32'd0);
    frame[0] = 8'h00; flen = 1;
    send_frame();
    check("len0.err", 32'(err), 32'd1);
    check("len0.busy", 32'(busy), 32'd0);
    check("len0.writes", 32'(wr_n), 32'd0);

    // N = 9 exceeds 32-byte memory
    pulse_start();
    frame[0] = 8'h09; flen = 1;
    send_frame();
    check("len9.err", 32'(err), 32'd1);
    check("len9.busy", 32'(busy), 32'd0);
    check("len9.writes", 32'(wr_n), 32'd0);
    check("len9.words_loaded", 32'(words_loaded), 32'd2);

    // N = 8 fills memory to address 31
    wr_n = 0;
    frame[0] = 8'h08;
    x = 8'h00;
    for (int i = 1; i <= 32; i++) begin
      frame[i] = 8'(i * 37 + 5);
      x = x ^ frame[i];
    end
    frame[33] = x;
    flen = 34;
    pulse_start();
    send_frame();
    repeat (2) @(negedge clk);
    check("full.cpu_run", 32'(cpu_run), 32'd1);
    check("full.err", 32'(err), 32'd0);
    check("full.words_loaded", 32'(words_loaded), 32'd8);
    check_writes(32, 1'b1);

    // Stalls plus a stray start during DATA
    wr_n = 0;
    set_nominal(8'h2F);
    gaps = 1'b1;
    start_at = 4;
    pulse_start();
    send_frame();
    gaps = 1'b0;
    start_at = -1;
    repeat (2) @(negedge clk);
    check("gap.cpu_run", 32'(cpu_run), 32'd1);
    check("gap.err", 32'(err), 32'd0);
    check("gap.words_loaded", 32'(words_loaded), 32'd2);
    check_writes(8, 1'b0);

    // Async reset after 5 payload bytes, write strobe pending
    wr_n = 0;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(frame[i]);
    check("rst.pending_we", 32'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_n = 0;
    pulse_start();
    send_frame();
    check("postrst.cpu_run", 32'(cpu_run), 32'd1);
    check("postrst.words_loaded", 32'(words_loaded), 32'd2);
    check_writes(8, 1'b1);

    // Reload a 1-word frame from DONE
    wr_n = 0;
    check("reload.pre_cpu_run", 32'(cpu_run), 32'd1);
    pulse_start();
    check("reload.cpu_run_dropped", 32'(cpu_run), 32'd0);
    check("reload.busy", 32'(busy), 32'd1);
    frame[0] = 8'h01;
    frame[1] = 8'h11; frame[2] = 8'h22; frame[3] = 8'h33; frame[4] = 8'h44;
    frame[5] = 8'h44;
    flen = 6;
    send_frame();
    check("reload.cpu_run", 32'(cpu_run), 32'd1);
    check("reload.words_loaded", 32'(words_loaded), 32'd1);
    check_writes(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
